// File: rtl/ps2_mouse_cursor_tracker.sv
// rtl/ps2_mouse_cursor_tracker.sv - PS/2 mouse packet parser driving a clamped absolute cursor.
// Optional PS2_MOUSE_ACCEL_EN doubles axis deltas whose magnitude exceeds ACCEL_THRESH.
module ps2_mouse_cursor_tracker #(
  parameter int MAX_X          = 639,
  parameter int MAX_Y          = 479,
  parameter int POS_W          = 10,
  parameter int WHEEL_MODE     = 0,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int ACCEL_THRESH   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       ps2_byte,
  input  logic             ps2_byte_en,
  input  logic             pos_load,
  input  logic [POS_W-1:0] load_x,
  input  logic [POS_W-1:0] load_y,
  output logic [POS_W-1:0] cursor_x,
  output logic [POS_W-1:0] cursor_y,
  output logic [2:0]       buttons,
  output logic [7:0]       wheel_delta,
  output logic             packet_ready,
  output logic             sync_error
);

  localparam int AW    = POS_W + 2;
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [POS_W-1:0]        MAX_X_P = POS_W'(MAX_X);
  localparam logic [POS_W-1:0]        MAX_Y_P = POS_W'(MAX_Y);
  localparam logic signed [AW-1:0]    MAX_X_S = AW'(MAX_X);
  localparam logic signed [AW-1:0]    MAX_Y_S = AW'(MAX_Y);
  localparam logic signed [9:0]       THR     = 10'(ACCEL_THRESH);
`ifdef PS2_MOUSE_ACCEL_EN
  localparam bit ACCEL_ON = 1'b1;
`else
  localparam bit ACCEL_ON = 1'b0;
`endif

  typedef enum logic [1:0] {WAIT_B0, GET_B1, GET_B2, GET_B3} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // Header byte minus the always-one sync bit: {yovf, xovf, ysgn, xsgn, btn[2:0]}
  logic [6:0]         hdr_q, hdr_d;
  logic [7:0]         b1_q, b1_d;
  logic [7:0]         b2_q, b2_d;
  logic [POS_W-1:0]   cursor_x_q, cursor_x_d;
  logic [POS_W-1:0]   cursor_y_q, cursor_y_d;
  logic [2:0]         buttons_q, buttons_d;
  logic [7:0]         wheel_q, wheel_d;
  logic               ready_q, ready_d;
  logic               err_q, err_d;

  logic               is_last;
  logic               reject;
  logic               timeout_hit;
  logic               pkt_done;
  logic [7:0]         y_byte;
  logic signed [AW-1:0] dx, dy, sum_x, sum_y;
  logic [POS_W-1:0]   new_x, new_y;

  function automatic logic signed [AW-1:0] axis_delta(input logic ovf, input logic sgn,
                                                      input logic [7:0] mag);
    logic signed [9:0] d;
    if (ovf) d = sgn ? -10'sd255 : 10'sd255;
    else     d = {sgn, sgn, mag};
    if (ACCEL_ON && ((d > THR) || (d < -THR))) d = d <<< 1;
    return AW'(d);
  endfunction

  assign is_last     = (state_q == GET_B3) || ((state_q == GET_B2) && (WHEEL_MODE == 0));
  assign reject      = ps2_byte_en && (state_q == WAIT_B0) && !ps2_byte[3];
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state_q != WAIT_B0) && !ps2_byte_en &&
                       (cnt_q == CNT_LAST);
  assign pkt_done    = ps2_byte_en && is_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= WAIT_B0;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (timeout_hit) begin
      state_d = WAIT_B0;
    end else if (ps2_byte_en) begin
      case (state_q)
        WAIT_B0: state_d = ps2_byte[3] ? GET_B1 : WAIT_B0;
        GET_B1:  state_d = GET_B2;
        GET_B2:  state_d = (WHEEL_MODE != 0) ? GET_B3 : WAIT_B0;
        default: state_d = WAIT_B0;
      endcase
    end
  end

  // The Y byte is still on the bus when a 3-byte packet completes.
  assign y_byte = (state_q == GET_B2) ? ps2_byte : b2_q;
  assign dx     = axis_delta(hdr_q[5], hdr_q[3], b1_q);
  assign dy     = axis_delta(hdr_q[6], hdr_q[4], y_byte);
  assign sum_x  = $signed({2'b00, cursor_x_q}) + dx;
  assign sum_y  = $signed({2'b00, cursor_y_q}) - dy;

  always_comb begin
    new_x = sum_x[POS_W-1:0];
    if (sum_x[AW-1])          new_x = '0;
    else if (sum_x > MAX_X_S) new_x = MAX_X_P;
    new_y = sum_y[POS_W-1:0];
    if (sum_y[AW-1])          new_y = '0;
    else if (sum_y > MAX_Y_S) new_y = MAX_Y_P;
  end

  always_comb begin
    cnt_d      = cnt_q + CNT_W'(1);
    hdr_d      = hdr_q;
    b1_d       = b1_q;
    b2_d       = b2_q;
    cursor_x_d = cursor_x_q;
    cursor_y_d = cursor_y_q;
    buttons_d  = buttons_q;
    wheel_d    = wheel_q;
    ready_d    = pkt_done;
    err_d      = reject || timeout_hit;

    if ((TIMEOUT_CYCLES == 0) || ps2_byte_en || (state_q == WAIT_B0) || timeout_hit)
      cnt_d = '0;

    if (ps2_byte_en && (state_q == WAIT_B0) && ps2_byte[3])
      hdr_d = {ps2_byte[7:4], ps2_byte[2:0]};
    if (ps2_byte_en && (state_q == GET_B1)) b1_d = ps2_byte;
    if (ps2_byte_en && (state_q == GET_B2)) b2_d = ps2_byte;

    if (pkt_done) begin
      cursor_x_d = new_x;
      cursor_y_d = new_y;
      buttons_d  = hdr_q[2:0];
      wheel_d    = (WHEEL_MODE != 0) ? {{4{ps2_byte[3]}}, ps2_byte[3:0]} : 8'h00;
    end
    // A host load overrides any motion completing in the same cycle.
    if (pos_load) begin
      cursor_x_d = (load_x > MAX_X_P) ? MAX_X_P : load_x;
      cursor_y_d = (load_y > MAX_Y_P) ? MAX_Y_P : load_y;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      hdr_q      <= '0;
      b1_q       <= '0;
      b2_q       <= '0;
      cursor_x_q <= POS_W'(MAX_X / 2);
      cursor_y_q <= POS_W'(MAX_Y / 2);
      buttons_q  <= '0;
      wheel_q    <= '0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      hdr_q      <= hdr_d;
      b1_q       <= b1_d;
      b2_q       <= b2_d;
      cursor_x_q <= cursor_x_d;
      cursor_y_q <= cursor_y_d;
      buttons_q  <= buttons_d;
      wheel_q    <= wheel_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
    end
  end

  assign cursor_x     = cursor_x_q;
  assign cursor_y     = cursor_y_q;
  assign buttons      = buttons_q;
  assign wheel_delta  = wheel_q;
  assign packet_ready = ready_q;
  assign sync_error   = err_q;

endmodule

// File: doc/ps2_mouse_cursor_tracker.md
Name: ps2_mouse_cursor_tracker

Overview:
Successor to the 3-byte mouse packet parser. Assembles 3-byte standard or 4-byte wheel-mode PS/2 mouse packets and resynchronises on framing errors or inter-byte timeouts. Converts the packet deltas into a clamped absolute cursor position sized to a parametrised screen, plus button and wheel outputs. Sits between the PS/2 byte receiver and the display/cursor overlay logic.

Parameters:
MAX_X, 639, largest legal cursor X; cursor_x range is 0..MAX_X.
MAX_Y, 479, largest legal cursor Y; cursor_y range is 0..MAX_Y.
POS_W, 10, width of the cursor_x, cursor_y and load ports; must hold MAX_X and MAX_Y.
WHEEL_MODE, 0, selects packet length: 0 = 3-byte packets, 1 = 4-byte packets with wheel byte.
TIMEOUT_CYCLES, 2000000, idle clocks allowed mid-packet before discard; 0 disables the timeout.
ACCEL_THRESH, 32, delta-magnitude threshold for acceleration; used only with the optional feature.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ps2_byte  in  8  received PS/2 byte
ps2_byte_en  in  1  single-cycle strobe; ps2_byte is valid in this cycle
pos_load  in  1  load the cursor position from load_x and load_y
load_x  in  POS_W  X value for pos_load
load_y  in  POS_W  Y value for pos_load
cursor_x  out  POS_W  absolute cursor X
cursor_y  out  POS_W  absolute cursor Y; 0 is the top row
buttons  out  3  button state as {middle, right, left}
wheel_delta  out  8  signed wheel movement of the last packet
packet_ready  out  1  one-cycle pulse when a packet completes
sync_error  out  1  one-cycle pulse on a rejected byte or a timeout

Behaviour:
- Reset (async assert, sync release): cursor_x = MAX_X/2 and cursor_y = MAX_Y/2 (integer division); buttons = 0, wheel_delta = 0, packet_ready = 0, sync_error = 0; FSM in WAIT_B0; timeout counter = 0.
- FSM states: WAIT_B0 -> GET_B1 -> GET_B2 -> (WHEEL_MODE ? GET_B3 : WAIT_B0); GET_B3 -> WAIT_B0. The FSM advances only on ps2_byte_en.
- WAIT_B0: a byte is accepted only if bit3 = 1. Otherwise sync_error pulses in the next cycle and the state stays WAIT_B0.
- Timeout: the counter clears on every strobe and increments each idle cycle in states other than WAIT_B0. When it reaches TIMEOUT_CYCLES-1: the partial packet is discarded, the FSM returns to WAIT_B0 and sync_error pulses. A strobe arriving in the expiry cycle wins: the byte is accepted and no error is raised.
- Strobes on back-to-back cycles are supported.
- Final byte: all outputs update, and packet_ready pulses, in the cycle after the final strobe (latency 1).
- dx = byte0[6] ? (byte0[4] ? -255 : +255) : {byte0[4], byte1}, a 9-bit signed value.
- dy is formed the same way using byte0[7], byte0[5] and byte2.
- X update: new_x = cursor_x + dx; new_x is then clamped to 0..MAX_X. Arithmetic is signed at POS_W+2 bits.
- Y update: new_y = cursor_y - dy, because PS/2 +Y is up. new_y is clamped to 0..MAX_Y.
- buttons = byte0[2:0].
- wheel_delta = sign-extended byte3[3:0] when WHEEL_MODE = 1; it is always 0 when WHEEL_MODE = 0.
- pos_load (any cycle): cursor_x and cursor_y take load_x and load_y, each clamped to the max, in the next cycle.
- pos_load in the same cycle as a packet completion: the load wins and the packet's motion is discarded. Buttons and wheel still update and packet_ready still pulses.
- Reset asserted mid-packet: the partial packet is lost and the FSM returns to WAIT_B0.

Optional Feature:
PS2_MOUSE_ACCEL_EN
- Defined: for each axis, if |delta| > ACCEL_THRESH the delta is doubled (10-bit signed) before the add and clamp. Overflow-substituted values (±255) are also doubled.
- Undefined: deltas are applied 1:1 and ACCEL_THRESH is ignored.

Test Plan:
Reset -> cursor (319,239), buttons 000, wheel_delta 0x00, no pulses. Then bytes 0x09, 0x05, 0x03 -> one cycle after the 3rd strobe: packet_ready = 1, buttons = 001, cursor (324,236).
From (319,239), four packets of 0x18, 0x9C, 0x00 (dx = -100) -> cursor_x steps 219, 119, 19, then clamps to 0.
From (319,239), X-overflow packet 0x48, 0x00, 0x00 -> cursor_x = 574; a second identical packet -> cursor_x clamps to 639.
Byte 0x01 in WAIT_B0 -> sync_error pulse, no advance. Then 0x08, 0x10 followed by TIMEOUT_CYCLES idle -> sync_error pulse. Then 0x08, 0x01, 0x01 -> cursor moves (+1, -1).
WHEEL_MODE = 1: bytes 0x08, 0x00, 0x00, 0x0F -> packet_ready after the 4th strobe only, wheel_delta = 0xFF, cursor unchanged.
pos_load with load_x = 700, load_y = 5 coincident with completion of packet 0x0A, 0x05, 0x05 -> cursor (639,5), buttons = 010, packet_ready = 1.
